// File: rtl/frame_writer.sv
// frame_writer: buffers 64-bit pixel words from the recorder in a small FIFO
// and writes them to a double-buffered frame store over a valid/ready bus.
// The camera cannot be stalled, so FIFO overflow and short frames are only
// flagged (sticky), never back-pressured.
module frame_writer #(
    parameter int                DEPTH_LOG2  = 4,
    parameter int                ADDR_W      = 24,
    parameter int                FRAME_WORDS = 259200,
    parameter logic [ADDR_W-1:0] BASE0       = 24'h000000,
    parameter logic [ADDR_W-1:0] BASE1       = 24'h040000
) (
    input  logic              par_clock,
    input  logic              reset_n,
    input  logic              FS,
    input  logic              we,
    input  logic [63:0]       pixels,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_data,
    output logic              wr_buf,
    output logic              frame_done,
    output logic              done_buf,
    output logic              overflow,
    output logic              err_short
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int CNT_W = $clog2(FRAME_WORDS + 1);
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_WORDS);

    typedef enum logic {
        WAIT_SOF,
        STREAM
    } state_t;

    // Input capture stage
    logic              fsIn_q;
    logic              weIn_q;
    logic [63:0]       pixIn_q;

    // FIFO storage and pointers (extra MSB distinguishes full from empty)
    logic [64:0]       fifoMem_q [DEPTH];
    logic [PW-1:0]     wrPtr_q;
    logic [PW-1:0]     rdPtr_q;
    logic              sofPend_q;
    logic              sofPend_d;
    logic              overflow_q;
    logic              overflow_d;

    // Output-side state
    state_t            state_q;
    state_t            state_d;
    state_t            stateEff;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              last_q;
    logic              last_d;
    logic              memValid_q;
    logic              memValid_d;
    logic [ADDR_W-1:0] memAddr_q;
    logic [ADDR_W-1:0] memAddr_d;
    logic [63:0]       memData_q;
    logic [63:0]       memData_d;
    logic              wrBuf_q;
    logic              wrBuf_d;
    logic              bufEff;
    logic              frameDone_q;
    logic              frameDone_d;
    logic              doneBuf_q;
    logic              doneBuf_d;
    logic              errShort_q;
    logic              errShort_d;

    logic              fifoEmpty;
    logic              fifoFull;
    logic              sofTag;
    logic              pushOk;
    logic              dropWord;
    logic              accept;
    logic              finish;
    logic              pop;
    logic [64:0]       headWord;

    assign fifoEmpty = (wrPtr_q == rdPtr_q);
    assign fifoFull  = (wrPtr_q[DEPTH_LOG2] != rdPtr_q[DEPTH_LOG2]) &&
                       (wrPtr_q[DEPTH_LOG2-1:0] == rdPtr_q[DEPTH_LOG2-1:0]);
    assign headWord  = fifoMem_q[rdPtr_q[DEPTH_LOG2-1:0]];

    assign accept    = memValid_q & mem_ready;
    assign finish    = accept & last_q;
    assign pop       = (~memValid_q | mem_ready) & ~fifoEmpty;

    // A pop in the same cycle frees a slot, so a push at full still succeeds.
    assign sofTag    = sofPend_q | fsIn_q;
    assign pushOk    = weIn_q & (~fifoFull | pop);
    assign dropWord  = weIn_q & fifoFull & ~pop;
    assign sofPend_d = pushOk ? 1'b0 : sofTag;
    assign overflow_d = overflow_q | dropWord;

    // Register the recorder's strobes so push decisions use stable inputs
    always_ff @(posedge par_clock or negedge reset_n) begin
        if (!reset_n) begin
            fsIn_q  <= 1'b0;
            weIn_q  <= 1'b0;
            pixIn_q <= '0;
        end else begin
            fsIn_q  <= FS;
            weIn_q  <= we;
            pixIn_q <= pixels;
        end
    end

    // FIFO data array; contents are don't-care while the pointers say empty
    always_ff @(posedge par_clock) begin
        if (pushOk) begin
            fifoMem_q[wrPtr_q[DEPTH_LOG2-1:0]] <= {sofTag, pixIn_q};
        end
    end

    // FIFO pointers, pending start-of-frame tag and sticky overflow flag
    always_ff @(posedge par_clock or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            sofPend_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (pushOk) begin
                wrPtr_q <= wrPtr_q + PW'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + PW'(1);
            end
            sofPend_q  <= sofPend_d;
            overflow_q <= overflow_d;
        end
    end

    // Frame sequencing: decide what each popped word does, with the
    // completion of the final word taking effect before the popped word
    always_comb begin
        stateEff    = finish ? WAIT_SOF : state_q;
        bufEff      = wrBuf_q ^ finish;
        state_d     = stateEff;
        wrBuf_d     = bufEff;
        memValid_d  = memValid_q & ~accept;
        memAddr_d   = memAddr_q;
        memData_d   = memData_q;
        count_d     = count_q;
        last_d      = last_q;
        errShort_d  = errShort_q;
        frameDone_d = finish;
        doneBuf_d   = finish ? wrBuf_q : doneBuf_q;
        if (pop) begin
            if (headWord[64]) begin
                memValid_d = 1'b1;
                memAddr_d  = bufEff ? BASE1 : BASE0;
                memData_d  = headWord[63:0];
                count_d    = CNT_W'(1);
                last_d     = (FRAME_CNT == CNT_W'(1));
                state_d    = STREAM;
                if (stateEff == STREAM) begin
                    errShort_d = 1'b1;
                end
            end else if (stateEff == STREAM) begin
                memValid_d = 1'b1;
                memAddr_d  = memAddr_q + ADDR_W'(1);
                memData_d  = headWord[63:0];
                count_d    = count_q + CNT_W'(1);
                last_d     = ((count_q + CNT_W'(1)) == FRAME_CNT);
            end
        end
    end

    // Output request register, buffer selection and status flags
    always_ff @(posedge par_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= WAIT_SOF;
            count_q     <= '0;
            last_q      <= 1'b0;
            memValid_q  <= 1'b0;
            memAddr_q   <= '0;
            memData_q   <= '0;
            wrBuf_q     <= 1'b0;
            frameDone_q <= 1'b0;
            doneBuf_q   <= 1'b0;
            errShort_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            last_q      <= last_d;
            memValid_q  <= memValid_d;
            memAddr_q   <= memAddr_d;
            memData_q   <= memData_d;
            wrBuf_q     <= wrBuf_d;
            frameDone_q <= frameDone_d;
            doneBuf_q   <= doneBuf_d;
            errShort_q  <= errShort_d;
        end
    end

    assign mem_valid  = memValid_q;
    assign mem_addr   = memAddr_q;
    assign mem_data   = memData_q;
    assign wr_buf     = wrBuf_q;
    assign frame_done = frameDone_q;
    assign done_buf   = doneBuf_q;
    assign overflow   = overflow_q;
    assign err_short  = errShort_q;

endmodule

// File: tb/tb_frame_writer.sv
// tb_frame_writer: directed vector table plus randomized frames checked
// against a word-level frame model kept in the bench.
module tb_frame_writer;

    localparam int          FW = 8;
    localparam logic [23:0] B0 = 24'h000000;
    localparam logic [23:0] B1 = 24'h040000;

    logic        par_clock = 1'b0;
    logic        reset_n   = 1'b0;
    logic        FS        = 1'b0;
    logic        we        = 1'b0;
    logic [63:0] pixels    = '0;
    logic        mem_ready = 1'b0;
    logic        mem_valid;
    logic [23:0] mem_addr;
    logic [63:0] mem_data;
    logic        wr_buf;
    logic        frame_done;
    logic        done_buf;
    logic        overflow;
    logic        err_short;

    frame_writer #(
        .DEPTH_LOG2 (4),
        .ADDR_W     (24),
        .FRAME_WORDS(FW),
        .BASE0      (B0),
        .BASE1      (B1)
    ) dut (
        .par_clock (par_clock),
        .reset_n   (reset_n),
        .FS        (FS),
        .we        (we),
        .pixels    (pixels),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .wr_buf    (wr_buf),
        .frame_done(frame_done),
        .done_buf  (done_buf),
        .overflow  (overflow),
        .err_short (err_short)
    );

    // 100 MHz pixel clock
    always #5 par_clock = ~par_clock;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [23:0] a;
        logic [63:0] d;
    } txn_t;

    // Word-level reference model of the frame rules
    int   mState;
    int   mCnt;
    logic mBuf;
    logic mPend;
    logic mErr;
    txn_t expQ[$];
    logic expDoneQ[$];
    int   sent;
    int   accepted;
    int   discarded;
    bit   monOn = 1'b0;
    int   readyMode = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void modelWord(input bit sof, input logic [63:0] pix);
        txn_t t;
        if (sof) begin
            if (mState == 1) mErr = 1'b1;
            mState = 1;
            mCnt   = 1;
        end else if (mState == 1) begin
            mCnt++;
        end else begin
            discarded++;
            return;
        end
        t.a = (mBuf ? B1 : B0) + 24'(mCnt - 1);
        t.d = pix;
        expQ.push_back(t);
        if (mCnt == FW) begin
            expDoneQ.push_back(mBuf);
            mBuf   = ~mBuf;
            mState = 0;
        end
    endfunction

    // Scoreboard: every accepted request and every frame_done pulse is
    // matched against the model's expectations
    txn_t monT;
    logic monE;
    always @(negedge par_clock) begin
        if (monOn && reset_n) begin
            if (mem_valid && mem_ready) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_txn: got addr %0h expected none", mem_addr);
                end else begin
                    monT = expQ.pop_front();
                    checkOutput("txn_addr", {40'd0, mem_addr}, {40'd0, monT.a});
                    checkOutput("txn_data", mem_data, monT.d);
                end
                accepted++;
            end
            if (frame_done) begin
                if (expDoneQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_done: got done_buf %0d expected no pulse", done_buf);
                end else begin
                    monE = expDoneQ.pop_front();
                    checkOutput("done_buf", {63'd0, done_buf}, {63'd0, monE});
                end
            end
        end
    end

    task automatic tick();
        @(posedge par_clock);
        #1;
        case (readyMode)
            0:       mem_ready = 1'b1;
            1:       mem_ready = ($urandom_range(3) != 0);
            default: mem_ready = 1'b0;
        endcase
    endtask

    task automatic applyStimulus(input bit fs, input logic [63:0] pix);
        int guard = 0;
        while ((sent - accepted - discarded) >= 14) begin
            tick();
            guard++;
            if (guard > 1000) begin
                total++;
                bad++;
                $display("[TB] FAIL throttle_timeout: got inflight %0d expected below 14", sent - accepted - discarded);
                break;
            end
        end
        FS     = fs;
        we     = 1'b1;
        pixels = pix;
        modelWord(fs | mPend, pix);
        mPend = 1'b0;
        sent++;
        tick();
        FS = 1'b0;
        we = 1'b0;
    endtask

    task automatic sendFs();
        FS    = 1'b1;
        mPend = 1'b1;
        tick();
        FS = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while ((expQ.size() != 0 || expDoneQ.size() != 0) && guard < 500) begin
            tick();
            guard++;
        end
        if (guard >= 500) begin
            total++;
            bad++;
            $display("[TB] FAIL drain_timeout: got %0d words pending expected 0", expQ.size());
        end
        repeat (3) tick();
    endtask

    task automatic doReset();
        monOn     = 1'b0;
        reset_n   = 1'b0;
        FS        = 1'b0;
        we        = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge par_clock);
        #1;
        mState = 0; mCnt = 0; mBuf = 1'b0; mPend = 1'b0; mErr = 1'b0;
        expQ.delete();
        expDoneQ.delete();
        sent = 0; accepted = 0; discarded = 0;
        reset_n = 1'b1;
        monOn   = 1'b1;
    endtask

    typedef struct {
        bit          fs;
        bit          we;
        logic [63:0] pix;
        bit          rdy;
        bit          expValid;
        logic [23:0] expAddr;
        logic [63:0] expData;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Words before any FS are discarded; the first FS word lands at
        // BASE0 two edges after it is strobed
        vecs[0] = '{0, 1, 64'hAAAA, 1, 0, 24'h0, 64'h0};
        vecs[1] = '{0, 1, 64'hBBBB, 1, 0, 24'h0, 64'h0};
        vecs[2] = '{0, 0, 64'h0,    1, 0, 24'h0, 64'h0};
        vecs[3] = '{1, 1, 64'hCCCC, 1, 0, 24'h0, 64'h0};
        vecs[4] = '{0, 1, 64'hDDDD, 1, 0, 24'h0, 64'h0};
        vecs[5] = '{0, 0, 64'h0,    1, 1, 24'h0, 64'hCCCC};
        vecs[6] = '{0, 0, 64'h0,    1, 1, 24'h1, 64'hDDDD};
        vecs[7] = '{0, 0, 64'h0,    1, 0, 24'h0, 64'h0};

        repeat (2) @(posedge par_clock);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            FS = vecs[i].fs; we = vecs[i].we; pixels = vecs[i].pix; mem_ready = vecs[i].rdy;
            @(posedge par_clock);
            #1;
            checkOutput($sformatf("vec%0d_valid", i), {63'd0, mem_valid}, {63'd0, vecs[i].expValid});
            if (vecs[i].expValid) begin
                checkOutput($sformatf("vec%0d_addr", i), {40'd0, mem_addr}, {40'd0, vecs[i].expAddr});
                checkOutput($sformatf("vec%0d_data", i), mem_data, vecs[i].expData);
            end
        end
        FS = 1'b0; we = 1'b0;

        // Reset state
        doReset();
        checkOutput("rst_valid",  {63'd0, mem_valid},  64'd0);
        checkOutput("rst_addr",   {40'd0, mem_addr},   64'd0);
        checkOutput("rst_data",   mem_data,            64'd0);
        checkOutput("rst_wrbuf",  {63'd0, wr_buf},     64'd0);
        checkOutput("rst_done",   {63'd0, frame_done}, 64'd0);
        checkOutput("rst_donebuf",{63'd0, done_buf},   64'd0);
        checkOutput("rst_ovf",    {63'd0, overflow},   64'd0);
        checkOutput("rst_short",  {63'd0, err_short},  64'd0);

        // Two complete frames alternate buffers
        readyMode = 0;
        for (int i = 0; i < FW; i++) applyStimulus(i == 0, 64'h1000 + 64'(i));
        drain();
        checkOutput("f1_wrbuf",   {63'd0, wr_buf},   64'd1);
        checkOutput("f1_donebuf", {63'd0, done_buf}, 64'd0);
        sendFs();
        for (int i = 0; i < FW; i++) applyStimulus(1'b0, 64'h2000 + 64'(i));
        drain();
        checkOutput("f2_wrbuf",   {63'd0, wr_buf},   64'd0);
        checkOutput("f2_donebuf", {63'd0, done_buf}, 64'd1);

        // Extra words after a frame are dropped; short frame restarts the buffer
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 64'h3000 + 64'(i));
        for (int i = 0; i < 4; i++) applyStimulus(i == 0, 64'h4000 + 64'(i));
        for (int i = 0; i < FW; i++) applyStimulus(i == 0, 64'h5000 + 64'(i));
        drain();
        checkOutput("short_flag",  {63'd0, err_short}, 64'd1);
        checkOutput("short_wrbuf", {63'd0, wr_buf},    64'd1);
        checkOutput("short_ovf",   {63'd0, overflow},  64'd0);

        // Randomized frames with random back-pressure
        doReset();
        readyMode = 1;
        for (int f = 0; f < 30; f++) begin
            int len;
            len = ($urandom_range(4) == 0) ? int'($urandom_range(FW - 1, 1)) : FW;
            if ($urandom_range(1) == 1) begin
                sendFs();
                repeat ($urandom_range(2)) tick();
                applyStimulus(1'b0, {$urandom, $urandom});
            end else begin
                applyStimulus(1'b1, {$urandom, $urandom});
            end
            for (int i = 1; i < len; i++) begin
                if ($urandom_range(3) == 0) tick();
                applyStimulus(1'b0, {$urandom, $urandom});
            end
        end
        for (int i = 0; i < FW; i++) applyStimulus(i == 0, {$urandom, $urandom});
        readyMode = 0;
        drain();
        checkOutput("rand_short", {63'd0, err_short}, {63'd0, mErr});
        checkOutput("rand_wrbuf", {63'd0, wr_buf},    {63'd0, mBuf});
        checkOutput("rand_ovf",   {63'd0, overflow},  64'd0);

        // Stall with words every cycle: overflow, request held stable
        doReset();
        readyMode = 2;
        for (int i = 0; i < 17; i++) modelWord(i == 0, 64'h6000 + 64'(i));
        for (int i = 0; i < 20; i++) begin
            FS = (i == 0); we = 1'b1; pixels = 64'h6000 + 64'(i);
            tick();
        end
        FS = 1'b0; we = 1'b0;
        tick();
        checkOutput("ovf_flag",  {63'd0, overflow},  64'd1);
        checkOutput("ovf_valid", {63'd0, mem_valid}, 64'd1);
        checkOutput("ovf_data0", mem_data, 64'h6000);
        repeat (3) tick();
        checkOutput("ovf_data1", mem_data, 64'h6000);
        checkOutput("ovf_addr",  {40'd0, mem_addr}, 64'd0);
        readyMode = 0;
        drain();
        checkOutput("ovf_wrbuf", {63'd0, wr_buf}, 64'd1);

        // Asynchronous reset while a request is pending
        monOn = 1'b0;
        readyMode = 2;
        FS = 1'b1; we = 1'b1; pixels = 64'h7777;
        tick();
        FS = 1'b0; we = 1'b0;
        begin
            int g = 0;
            while (!mem_valid && g < 20) begin
                tick();
                g++;
            end
        end
        checkOutput("pre_rst_valid", {63'd0, mem_valid}, 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("arst_valid", {63'd0, mem_valid},  64'd0);
        checkOutput("arst_done",  {63'd0, frame_done}, 64'd0);
        checkOutput("arst_ovf",   {63'd0, overflow},   64'd0);
        checkOutput("arst_short", {63'd0, err_short},  64'd0);
        checkOutput("arst_wrbuf", {63'd0, wr_buf},     64'd0);

        // Fresh frame after reset goes to buffer 0
        doReset();
        readyMode = 0;
        for (int i = 0; i < FW; i++) applyStimulus(i == 0, 64'h8000 + 64'(i));
        drain();
        checkOutput("post_wrbuf", {63'd0, wr_buf}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
